// File: rtl/fxp_pkg.sv
// Shared types and helpers for the fixed-point multiply arbiter.
// The helpers use wide containers so that any legal WIDTH/NREQ can call them.
package fxp_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int FRAC_DEF  = 6;
    localparam int NREQ_DEF  = 4;
    localparam int MAXW      = 32;
    localparam int MAXREQ    = 32;

    typedef logic signed [WIDTH_DEF-1:0]   operand_t;
    typedef logic signed [2*WIDTH_DEF-1:0] product_t;
    typedef logic [$clog2(NREQ_DEF)-1:0]   id_t;

    typedef struct packed {
        logic            sat;
        logic [MAXW-1:0] value;
    } rescale_t;

    typedef struct packed {
        logic       found;
        logic [7:0] idx;
    } pick_t;

    // Round half up, drop FRAC bits, then clamp to the signed range of width bits.
    function automatic rescale_t fxp_rescale_sat(input logic signed [2*MAXW-1:0] product,
                                                 input int frac, input int width);
        logic signed [2*MAXW-1:0] r;
        logic signed [2*MAXW-1:0] max_v;
        logic signed [2*MAXW-1:0] min_v;
        rescale_t                 res;
        r     = (product + (64'sd1 <<< (frac - 1))) >>> frac;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (r > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v[MAXW-1:0];
        end else if (r < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v[MAXW-1:0];
        end else begin
            res.sat   = 1'b0;
            res.value = r[MAXW-1:0];
        end
        return res;
    endfunction

    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] valid, input int ptr, input int nreq);
        pick_t p;
        int    idx;
        p.found = 1'b0;
        p.idx   = 8'd0;
        for (int k = 0; k < MAXREQ; k++) begin
            if (k < nreq && !p.found) begin
                idx = (ptr + k) % nreq;
                if (valid[idx]) begin
                    p.found = 1'b1;
                    p.idx   = 8'(idx);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fxp_mul_pipe.sv
// Signed multiplier: one operand register followed by MUL_LAT product stages,
// with a matching id/valid side band. The whole chain freezes when en=0.
module fxp_mul_pipe
    import fxp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_a,
    input  logic [WIDTH-1:0]          in_b,
    input  logic [IDW-1:0]            in_id,
    output logic                      out_valid,
    output logic [IDW-1:0]            out_id,
    output logic signed [2*WIDTH-1:0] out_prod,
    output logic                      busy
);
    localparam int PW = 2 * WIDTH;

    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic [IDW-1:0]          id0_r;
    logic                    v0_r;
    logic signed [PW-1:0]    prod_r [MUL_LAT];
    logic [IDW-1:0]          id_r   [MUL_LAT];
    logic [MUL_LAT-1:0]      v_r;

    // Operand capture and product shift chain, advancing only while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            id0_r <= '0;
            v0_r  <= 1'b0;
            v_r   <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                prod_r[k] <= '0;
                id_r[k]   <= '0;
            end
        end else if (en) begin
            a_r       <= in_a;
            b_r       <= in_b;
            id0_r     <= in_id;
            v0_r      <= in_valid;
            prod_r[0] <= PW'(a_r) * PW'(b_r);
            id_r[0]   <= id0_r;
            v_r[0]    <= v0_r;
            for (int k = 1; k < MUL_LAT; k++) begin
                prod_r[k] <= prod_r[k-1];
                id_r[k]   <= id_r[k-1];
                v_r[k]    <= v_r[k-1];
            end
        end
    end

    assign out_valid = v_r[MUL_LAT-1];
    assign out_id    = id_r[MUL_LAT-1];
    assign out_prod  = prod_r[MUL_LAT-1];
    assign busy      = v0_r | (|v_r);

endmodule

// File: rtl/fxp_mul_arbiter.sv
// Round-robin front end sharing one pipelined fixed-point multiplier between NREQ
// requesters; results are rescaled, saturated and returned tagged with the requester id.
module fxp_mul_arbiter
    import fxp_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int FRAC    = 6,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_prod,
    output logic                    rsp_sat,
    output logic                    busy,
    output logic [CNT_W-1:0]        sat_cnt
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = 2 * WIDTH;

    logic [IDW-1:0]       ptr_r;
    logic [IDW-1:0]       grant_s;
    pick_t                pick_s;
    logic                 accept_s;
    logic [WIDTH-1:0]     op_a_s;
    logic [WIDTH-1:0]     op_b_s;
    logic                 pipe_valid_s;
    logic                 pipe_busy_s;
    logic [IDW-1:0]       pipe_id_s;
    logic signed [PW-1:0] pipe_prod_s;
    rescale_t             resc_s;

    // Grant search from ptr upward; ready stays low while frozen or held in reset.
    always_comb begin
        pick_s    = rr_pick(MAXREQ'(req_valid), int'(ptr_r), NREQ);
        grant_s   = pick_s.idx[IDW-1:0];
        req_ready = '0;
        if (en && !rst && pick_s.found) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s = |(req_valid & req_ready);
    assign op_a_s   = req_a[grant_s*WIDTH +: WIDTH];
    assign op_b_s   = req_b[grant_s*WIDTH +: WIDTH];

    // The requester just served becomes lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (accept_s) begin
            ptr_r <= (grant_s == IDW'(NREQ - 1)) ? '0 : grant_s + IDW'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    fxp_mul_pipe #(
        .WIDTH   (WIDTH),
        .IDW     (IDW),
        .MUL_LAT (MUL_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (accept_s),
        .in_a      (op_a_s),
        .in_b      (op_b_s),
        .in_id     (grant_s),
        .out_valid (pipe_valid_s),
        .out_id    (pipe_id_s),
        .out_prod  (pipe_prod_s),
        .busy      (pipe_busy_s)
    );

    assign resc_s = fxp_rescale_sat((2*MAXW)'(pipe_prod_s), FRAC, WIDTH);

    // Valid is cleared during a freeze so the held final stage is not emitted twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_sat   <= 1'b0;
        end else if (en && pipe_valid_s) begin
            rsp_valid <= 1'b1;
            rsp_id    <= pipe_id_s;
            rsp_prod  <= resc_s.value[WIDTH-1:0];
            rsp_sat   <= resc_s.sat;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

    // Saturation event counter, sticky at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (rsp_valid && rsp_sat && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + CNT_W'(1);
        end else begin
            sat_cnt <= sat_cnt;
        end
    end

    assign busy = pipe_busy_s | rsp_valid;

endmodule
